// File: rtl/div_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : div_sequencer_pkg
// Purpose : Shared definitions for the RV32M divide sequencer. These are the
//           divide-class funct3 encodings, the FSM state encoding, the
//           Execute result-mux selector value, and small decode helpers.
// Ports   : none (package)
// Options : none
// Revision: 1.0 - initial release
// ============================================================================
package div_sequencer_pkg;

  // funct3 encodings of the RV32M divide-class instructions
  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  // Execute-stage result mux input that carries the divider result
  localparam logic [2:0] EX_RES_SEL_DIV = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_ITER  = 3'd2,
    ST_FIXUP = 3'd3,
    ST_DONE  = 3'd4
  } div_state_e;

  // DIV and REM treat their operands as two's complement
  function automatic logic f3_is_signed(input logic [2:0] f3);
    return (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // REM and REMU return the remainder instead of the quotient
  function automatic logic f3_is_rem(input logic [2:0] f3);
    return (f3 == F3_REM) || (f3 == F3_REMU);
  endfunction

endpackage : div_sequencer_pkg
`default_nettype wire

// File: rtl/div_sequencer_step.sv
`default_nettype none
// ============================================================================
// Module  : div_step
// Purpose : One combinational radix-2 restoring division step. The
//           {rem,quo} pair shifts left by one. The divisor is subtracted
//           from the widened partial remainder, and the subtraction is kept
//           when it does not borrow.
// Ports   : rem_i     - partial remainder
//           quo_i     - quotient / remaining dividend bits
//           divisor_i - divisor magnitude
//           rem_o     - next partial remainder
//           quo_o     - next quotient, with the new bit in the LSB
// Options : none
// Revision: 1.0 - initial release
// ============================================================================
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             fits;
  logic             unused_trial_msb;

  assign shifted = {rem_i, quo_i[WIDTH-1]};
  // An extra guard bit keeps the borrow visible even when the shifted
  // remainder already uses bit WIDTH.
  assign trial   = {1'b0, shifted} - {2'b00, divisor_i};
  assign fits    = ~trial[WIDTH+1];

  // After a successful subtraction the remainder is below the divisor, so
  // bit WIDTH is zero. The only exception is a zero divisor, whose result
  // is replaced later.
  assign unused_trial_msb = trial[WIDTH];

  assign rem_o = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_o = {quo_i[WIDTH-2:0], fits};

endmodule : div_step
`default_nettype wire

// File: rtl/div_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : div_sequencer
// Purpose : Multi-cycle RV32M DIV/DIVU/REM/REMU controller for the Execute
//           stage. It runs a radix-2 restoring divider for WIDTH steps and
//           applies the RISC-V divide-by-zero and overflow results. It
//           stalls Execute while busy and pulses done_o with the result.
// Ports   : clk_i, reset_i     - clock, synchronous active-high reset
//           start_i, funct3_i  - divide-class request and its funct3
//           src_a_i, src_b_i   - dividend / divisor (post-forwarding)
//           flush_i            - abort; has priority over everything
//           hold_i             - external Execute stall; freezes DONE
//           stall_o            - hold Execute and earlier stages
//           done_o, result_o   - result valid strobe and value
//           busy_o             - FSM not in IDLE
// Options : DIV_RESULT_CACHE_EN - single-entry result cache. A repeated
//           operand pair completes one cycle after start.
// Revision: 1.0 - initial release
// ============================================================================
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [2:0]       funct3_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  input  logic             flush_i,
  input  logic             hold_i,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             busy_o
);

  import div_sequencer_pkg::*;

  localparam int               CNT_W   = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state_q, state_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, bmag_q, bmag_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             signed_q, signed_d;
  logic             negq_q, negq_d, negr_q, negr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall;

  logic [WIDTH-1:0] step_rem, step_quo;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] fix_quo, fix_rem;
  logic             cache_hit;
  logic [WIDTH-1:0] cache_result;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (bmag_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  // Operand magnitudes. These are used only in INIT, where a_q, b_q and
  // signed_q already hold the latched request.
  assign a_mag = (signed_q && a_q[WIDTH-1]) ? -a_q : a_q;
  assign b_mag = (signed_q && b_q[WIDTH-1]) ? -b_q : b_q;

  // RISC-V special cases come first. Otherwise, restore the signs.
  always_comb begin
    fix_quo = negq_q ? -quo_q : quo_q;
    fix_rem = negr_q ? -rem_q : rem_q;
    if (b_q == '0) begin
      fix_quo = '1;
      fix_rem = a_q;
    end else if (signed_q && (a_q == MIN_NEG) && (b_q == '1)) begin
      fix_quo = a_q;
      fix_rem = '0;
    end
  end

`ifdef DIV_RESULT_CACHE_EN
  logic             cache_valid_q;
  logic [WIDTH-1:0] cache_a_q, cache_b_q, cache_quo_q, cache_rem_q;
  logic             cache_signed_q;
  logic             cache_wr;

  assign cache_hit = cache_valid_q && (cache_a_q == src_a_i) &&
                     (cache_b_q == src_b_i) &&
                     (cache_signed_q == f3_is_signed(funct3_i));
  assign cache_result = f3_is_rem(funct3_i) ? cache_rem_q : cache_quo_q;
  // A flush in FIXUP leaves the entry untouched.
  assign cache_wr = (state_q == ST_FIXUP) && !flush_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cache_valid_q  <= 1'b0;
      cache_a_q      <= '0;
      cache_b_q      <= '0;
      cache_signed_q <= 1'b0;
      cache_quo_q    <= '0;
      cache_rem_q    <= '0;
    end else if (cache_wr) begin
      cache_valid_q  <= 1'b1;
      cache_a_q      <= a_q;
      cache_b_q      <= b_q;
      cache_signed_q <= signed_q;
      cache_quo_q    <= fix_quo;
      cache_rem_q    <= fix_rem;
    end
  end
`else
  assign cache_hit    = 1'b0;
  assign cache_result = '0;
`endif

  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    a_d      = a_q;
    b_d      = b_q;
    signed_d = signed_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    bmag_d   = bmag_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    stall    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          stall    = 1'b1;
          funct3_d = funct3_i;
          a_d      = src_a_i;
          b_d      = src_b_i;
          signed_d = f3_is_signed(funct3_i);
          if (cache_hit) begin
            state_d  = ST_DONE;
            result_d = cache_result;
          end else begin
            state_d  = ST_INIT;
          end
        end
      end
      ST_INIT: begin
        stall   = 1'b1;
        negq_d  = signed_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        negr_d  = signed_q & a_q[WIDTH-1];
        rem_d   = '0;
        quo_d   = a_mag;
        bmag_d  = b_mag;
        cnt_d   = '0;
        state_d = ST_ITER;
      end
      ST_ITER: begin
        stall = 1'b1;
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_FIXUP;
        end
      end
      ST_FIXUP: begin
        stall    = 1'b1;
        result_d = f3_is_rem(funct3_q) ? fix_rem : fix_quo;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        // A start_i seen here belongs to the instruction that just finished.
        if (!hold_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A flush aborts any state. The result register keeps its old value.
    if (flush_i) begin
      state_d  = ST_IDLE;
      stall    = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      funct3_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      bmag_q   <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      a_q      <= a_d;
      b_q      <= b_d;
      signed_q <= signed_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      bmag_q   <= bmag_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign stall_o  = stall & ~reset_i;
  assign done_o   = (state_q == ST_DONE) & ~flush_i;
  assign busy_o   = (state_q != ST_IDLE);
  assign result_o = result_q;

endmodule : div_sequencer
`default_nettype wire

// File: tb/tb_div_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_div_sequencer
// Purpose : Directed self-checking bench for div_sequencer. Expected values
//           and latencies are hand-computed constants.
// Ports   : none
// Options : DIV_RESULT_CACHE_EN - repeated operand pairs expect a one-cycle
//           latency.
// Revision: 1.0 - initial release
// ============================================================================
module tb_div_sequencer;

`ifdef DIV_RESULT_CACHE_EN
  localparam int HIT_LAT = 1;
`else
  localparam int HIT_LAT = 35;
`endif
  localparam int FULL_LAT = 35;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        start_i = 1'b0;
  logic [2:0]  funct3_i = 3'b000;
  logic [31:0] src_a_i = '0;
  logic [31:0] src_b_i = '0;
  logic        flush_i = 1'b0;
  logic        hold_i = 1'b0;
  logic        stall_o, done_o, busy_o;
  logic [31:0] result_o;

  int checks = 0;
  int errors = 0;

  div_sequencer #(.WIDTH(32)) dut (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .start_i  (start_i),
    .funct3_i (funct3_i),
    .src_a_i  (src_a_i),
    .src_b_i  (src_b_i),
    .flush_i  (flush_i),
    .hold_i   (hold_i),
    .stall_o  (stall_o),
    .done_o   (done_o),
    .result_o (result_o),
    .busy_o   (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one operation in the next cycle (T) and hold start_i until done.
  // Checks the stall profile, the latency and the result. Returns at the
  // negedge of the done cycle with start_i already dropped.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
    int n;
    logic stall_bad;
    @(negedge clk_i);
    start_i = 1'b1; funct3_i = f3; src_a_i = a; src_b_i = b;
    #1 chk({tag, "_stall_T"}, stall_o, 1);
    n = 0; stall_bad = 1'b0;
    while (n < 60) begin
      @(negedge clk_i);
      n++;
      if (done_o) break;
      if (!stall_o) stall_bad = 1'b1;
    end
    chk({tag, "_latency"}, n, exp_lat);
    chk({tag, "_result"}, result_o, exp_res);
    chk({tag, "_stall_busy"}, stall_bad, 0);
    chk({tag, "_stall_done"}, stall_o, 0);
    start_i = 1'b0;
  endtask

  initial begin
    int n;
    logic done_seen;

    // Reset: stall_o must stay low even with start_i asserted.
    start_i = 1'b1; funct3_i = 3'b101; src_a_i = 32'd1; src_b_i = 32'd1;
    repeat (2) @(negedge clk_i);
    chk("reset_stall", stall_o, 0);
    start_i = 1'b0;
    @(negedge clk_i);
    reset_i = 1'b0;
    chk("reset_done", done_o, 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_result", result_o, 0);

    // Basic unsigned and signed operations, issued back-to-back
    run_op("divu_100_7", 3'b101, 32'd100, 32'd7, FULL_LAT, 32'd14);
    run_op("remu_100_7", 3'b111, 32'd100, 32'd7, HIT_LAT, 32'd2);
    run_op("div_m20_3",  3'b100, -32'sd20, 32'd3, FULL_LAT, 32'hFFFF_FFFA);
    run_op("rem_m20_3",  3'b110, -32'sd20, 32'd3, HIT_LAT, 32'hFFFF_FFFE);
    run_op("div_20_m3",  3'b100, 32'd20, -32'sd3, FULL_LAT, 32'hFFFF_FFFA);
    run_op("rem_20_m3",  3'b110, 32'd20, -32'sd3, HIT_LAT, 32'd2);
    run_op("divu_max_1", 3'b101, 32'hFFFF_FFFF, 32'd1, FULL_LAT, 32'hFFFF_FFFF);

    // Special cases: division by zero and signed overflow
    run_op("div_5_0",    3'b100, 32'd5, 32'd0, FULL_LAT, 32'hFFFF_FFFF);
    run_op("rem_5_0",    3'b110, 32'd5, 32'd0, HIT_LAT, 32'd5);
    run_op("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, FULL_LAT, 32'h8000_0000);
    run_op("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, HIT_LAT, 32'd0);

    // Cache reuse: matching operands hit, a changed divisor misses.
    run_op("div_100_7",  3'b100, 32'd100, 32'd7, FULL_LAT, 32'd14);
    run_op("rem_100_7",  3'b110, 32'd100, 32'd7, HIT_LAT, 32'd2);
    run_op("div_100_6",  3'b100, 32'd100, 32'd6, FULL_LAT, 32'd16);

    // Flush at T+10: stall drops in the same cycle, then IDLE with no done.
    @(negedge clk_i);
    start_i = 1'b1; funct3_i = 3'b101; src_a_i = 32'd50; src_b_i = 32'd5;
    repeat (10) @(negedge clk_i);
    flush_i = 1'b1; start_i = 1'b0;
    #1 chk("flush_stall", stall_o, 0);
    @(negedge clk_i);
    flush_i = 1'b0;
    chk("flush_busy", busy_o, 0);
    done_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (done_o) done_seen = 1'b1;
    end
    chk("flush_no_done", done_seen, 0);
    run_op("divu_9_3", 3'b101, 32'd9, 32'd3, FULL_LAT, 32'd3);

    // hold_i for 3 cycles in DONE keeps done_o and result_o for 4 cycles.
    run_op("hold_op", 3'b101, 32'd1000, 32'd10, FULL_LAT, 32'd100);
    hold_i = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk_i);
      chk($sformatf("hold_done_%0d", i), done_o, 1);
      chk($sformatf("hold_result_%0d", i), result_o, 32'd100);
    end
    hold_i = 1'b0;
    @(negedge clk_i);
    chk("hold_release_done", done_o, 0);
    chk("hold_release_busy", busy_o, 0);

    // Reset mid-operation at T+20
    @(negedge clk_i);
    start_i = 1'b1; funct3_i = 3'b101; src_a_i = 32'd77; src_b_i = 32'd5;
    n = 0;
    repeat (20) @(negedge clk_i);
    reset_i = 1'b1; start_i = 1'b0;
    @(negedge clk_i);
    chk("midreset_busy", busy_o, 0);
    chk("midreset_result", result_o, 0);
    chk("midreset_done", done_o, 0);
    reset_i = 1'b0;
    @(negedge clk_i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_div_sequencer
`default_nettype wire
